// File: rtl/vec_pkg.sv
// ============================================================================
// Module  : vec_pkg
// Purpose : Shared types and constants for the vector load path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vec_pkg;

   localparam int REG_SEL_W = 4;
   localparam logic [3:0] OP_LOAD = 4'h1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2,
      WRITE   = 2'd3
   } load_state_t;

   function automatic int bytes_per_elem(input int bits);
      return (bits + 7) / 8;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vec_load_if.sv
// ============================================================================
// Module  : vec_load_if
// Purpose : Byte-stream input and register-bank write bundle of vec_load_unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface vec_load_if #(
   parameter int BITS = 8,
   parameter int N    = 2
);
   import vec_pkg::*;

   logic [7:0]           rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic [BITS-1:0]      data_out [N];
   logic [REG_SEL_W-1:0] sel_out;
   logic                 write;
   logic                 busy;
   logic                 err;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, data_out, sel_out, write, busy, err
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, data_out, sel_out, write, busy, err
   );

endinterface

`default_nettype wire

// File: rtl/vec_load_unit.sv
// ============================================================================
// Module  : vec_load_unit
// Purpose : Decodes a host LOAD frame and issues one vector register write.
//           Optional trailing XOR checksum when LOAD_CHECKSUM_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_load_unit
   import vec_pkg::*;
#(
   parameter int BITS = 8,
   parameter int N    = 2
) (
   input  logic      clk,
   input  logic      rst,
   vec_load_if.slave bus
);

   localparam int BPE   = bytes_per_elem(BITS);
   localparam int PLEN  = N * BPE;
   localparam int CNT_W = $clog2(PLEN + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PLEN - 1);

   load_state_t          state;
   load_state_t          state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [REG_SEL_W-1:0] sel_reg;
   logic [BITS-1:0]      data_reg [N];
   logic                 err_reg;

   logic ready;
   logic accept;
   logic pay_acc;
   logic hdr_ok;
   logic hdr_bad;
   logic last_byte;
   logic chk_bad;

`ifdef LOAD_CHECKSUM_EN
   logic [7:0] csum;
   logic       chk_ok;
`endif

   always_comb begin
      ready     = (state != WRITE);
      accept    = bus.rx_valid && ready;
      pay_acc   = accept && (state == PAYLOAD);
      hdr_ok    = accept && (state == IDLE) && (bus.rx_data[7:4] == OP_LOAD);
      hdr_bad   = accept && (state == IDLE) && (bus.rx_data[7:4] != OP_LOAD);
      last_byte = pay_acc && (cnt == LAST);
`ifdef LOAD_CHECKSUM_EN
      chk_ok    = accept && (state == CHECK) && (csum == bus.rx_data);
      chk_bad   = accept && (state == CHECK) && (csum != bus.rx_data);
`else
      chk_bad   = 1'b0;
`endif
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (hdr_ok) state_nxt = PAYLOAD;
         end
         PAYLOAD: begin
`ifdef LOAD_CHECKSUM_EN
            if (last_byte) state_nxt = CHECK;
`else
            if (last_byte) state_nxt = WRITE;
`endif
         end
         CHECK: begin
`ifdef LOAD_CHECKSUM_EN
            if (chk_ok)       state_nxt = WRITE;
            else if (chk_bad) state_nxt = IDLE;
`else
            state_nxt = IDLE;
`endif
         end
         WRITE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Each data bit is owned by exactly one payload byte slot, so partial
   // top bytes simply drop the bits above BITS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         sel_reg <= '0;
         err_reg <= 1'b0;
         for (int e = 0; e < N; e++) begin
            data_reg[e] <= '0;
         end
      end else begin
         err_reg <= hdr_bad || chk_bad;
         if (hdr_ok) begin
            sel_reg <= bus.rx_data[REG_SEL_W-1:0];
            cnt     <= '0;
         end else if (pay_acc) begin
            cnt <= cnt + 1'b1;
         end
         for (int e = 0; e < N; e++) begin
            for (int k = 0; k < BITS; k++) begin
               if (pay_acc && (cnt == CNT_W'(e * BPE + k / 8))) begin
                  data_reg[e][k] <= bus.rx_data[k % 8];
               end
            end
         end
      end
   end

`ifdef LOAD_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum <= 8'h00;
      end else if (hdr_ok) begin
         csum <= bus.rx_data;
      end else if (pay_acc) begin
         csum <= csum ^ bus.rx_data;
      end
   end
`endif

   assign bus.rx_ready = ready && !rst;
   assign bus.data_out = data_reg;
   assign bus.sel_out  = sel_reg;
   assign bus.write    = (state == WRITE);
   assign bus.busy     = (state != IDLE);
   assign bus.err      = err_reg;

endmodule

`default_nettype wire

// File: tb/tb_vec_load_unit.sv
// ============================================================================
// Module  : tb_vec_load_unit
// Purpose : Table-driven and scoreboard bench for vec_load_unit (BITS=8 and 12).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_load_unit;
   import vec_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vec_load_if #(.BITS(8),  .N(2)) bus ();
   vec_load_if #(.BITS(12), .N(2)) bus12 ();

   vec_load_unit #(.BITS(8),  .N(2)) dut   (.clk(clk), .rst(rst), .bus(bus));
   vec_load_unit #(.BITS(12), .N(2)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

   int n_checks = 0;
   int n_pass   = 0;
   int writes_seen = 0;
   int errs_seen   = 0;

   typedef struct packed {
      logic [3:0] sel;
      logic [7:0] d0;
      logic [7:0] d1;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [7:0] hdr;
      logic [7:0] p0;
      logic [7:0] p1;
      bit         wr;
      bit         er;
      logic [3:0] sel;
      logic [7:0] d0;
      logic [7:0] d1;
   } vec_t;
   vec_t tbl [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.err) errs_seen++;
         if (bus.write) begin
            writes_seen++;
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_write: got write with sel 0x%0h, want no write", bus.sel_out);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_sel", 32'(bus.sel_out), 32'(e.sel));
               check("sb_d0", 32'(bus.data_out[0]), 32'(e.d0));
               check("sb_d1", 32'(bus.data_out[1]), 32'(e.d1));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int bound = 0;
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      while (!bus.rx_ready && bound < 50) begin
         @(negedge clk);
         bound++;
      end
      if (bound >= 50) begin
         n_checks++;
         $display("FAIL rx_ready_timeout: got ready=0, want ready=1");
      end
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_byte12(input logic [7:0] b);
      int bound = 0;
      @(negedge clk);
      bus12.rx_data  = b;
      bus12.rx_valid = 1'b1;
      while (!bus12.rx_ready && bound < 50) begin
         @(negedge clk);
         bound++;
      end
      if (bound >= 50) begin
         n_checks++;
         $display("FAIL rx_ready12_timeout: got ready=0, want ready=1");
      end
      @(posedge clk);
      #1;
      bus12.rx_valid = 1'b0;
   endtask

   // Header plus two payload bytes, plus the XOR trailer when built with checksums.
   task automatic send_frame(input logic [7:0] h, input logic [7:0] p0, input logic [7:0] p1, input int gap);
      send_byte(h);
      idle(gap);
      send_byte(p0);
      idle(gap);
      send_byte(p1);
`ifdef LOAD_CHECKSUM_EN
      idle(gap);
      send_byte(h ^ p0 ^ p1);
`endif
   endtask

   task automatic expect_write(input logic [3:0] s, input logic [7:0] d0, input logic [7:0] d1);
      exp_t e;
      e.sel = s;
      e.d0  = d0;
      e.d1  = d1;
      sb.push_back(e);
   endtask

   initial begin
      int w0;
      int e0;
      logic [7:0] ck12;

      tbl[0] = '{8'h10, 8'h0F, 8'h3C, 1'b1, 1'b0, 4'h0, 8'h0F, 8'h3C};
      tbl[1] = '{8'h21, 8'h00, 8'h00, 1'b0, 1'b1, 4'h0, 8'h0F, 8'h3C};
      tbl[2] = '{8'h12, 8'h01, 8'h00, 1'b1, 1'b0, 4'h2, 8'h01, 8'h00};
      tbl[3] = '{8'h1F, 8'h80, 8'h01, 1'b1, 1'b0, 4'hF, 8'h80, 8'h01};
      tbl[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 4'hF, 8'h80, 8'h01};
      tbl[5] = '{8'hF5, 8'h00, 8'h00, 1'b0, 1'b1, 4'hF, 8'h80, 8'h01};
      tbl[6] = '{8'h1A, 8'h00, 8'hFF, 1'b1, 1'b0, 4'hA, 8'h00, 8'hFF};

      rst = 1'b1;
      bus.rx_data    = 8'h00;
      bus.rx_valid   = 1'b0;
      bus12.rx_data  = 8'h00;
      bus12.rx_valid = 1'b0;
      idle(3);
      check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
      check("rst_write", 32'(bus.write), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_sel", 32'(bus.sel_out), 32'd0);
      check("rst_d0", 32'(bus.data_out[0]), 32'd0);
      check("rst_d1", 32'(bus.data_out[1]), 32'd0);
      rst = 1'b0;
      idle(1);
      check("idle_rx_ready", 32'(bus.rx_ready), 32'd1);

      // Write latency and single-cycle strobe.
      w0 = writes_seen;
      expect_write(4'h0, 8'h0F, 8'h3C);
      send_frame(8'h10, 8'h0F, 8'h3C, 0);
      check("lat_write", 32'(bus.write), 32'd1);
      check("lat_rx_ready", 32'(bus.rx_ready), 32'd0);
      check("lat_busy", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      check("post_write", 32'(bus.write), 32'd0);
      check("post_busy", 32'(bus.busy), 32'd0);
      idle(2);
      check("t1_writes", 32'(writes_seen - w0), 32'd1);

      // Invalid header: err the next cycle, no write.
      w0 = writes_seen;
      e0 = errs_seen;
      send_byte(8'h21);
      check("bad_err_pulse", 32'(bus.err), 32'd1);
      check("bad_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      check("bad_err_clear", 32'(bus.err), 32'd0);
      expect_write(4'h2, 8'h01, 8'h00);
      send_frame(8'h12, 8'h01, 8'h00, 0);
      idle(3);
      check("t2_writes", 32'(writes_seen - w0), 32'd1);
      check("t2_errs", 32'(errs_seen - e0), 32'd1);

      // Gaps of 3 cycles between bytes.
      w0 = writes_seen;
      expect_write(4'h1, 8'hFF, 8'h7E);
      send_frame(8'h11, 8'hFF, 8'h7E, 3);
      idle(3);
      check("t3_writes", 32'(writes_seen - w0), 32'd1);
      check("t3_sel_hold", 32'(bus.sel_out), 32'd1);
      check("t3_d1_hold", 32'(bus.data_out[1]), 32'h7E);

      for (int i = 0; i < 7; i++) begin
         w0 = writes_seen;
         e0 = errs_seen;
         if (tbl[i].wr) begin
            expect_write(tbl[i].sel, tbl[i].d0, tbl[i].d1);
            send_frame(tbl[i].hdr, tbl[i].p0, tbl[i].p1, 0);
         end else begin
            send_byte(tbl[i].hdr);
         end
         idle(3);
         check($sformatf("tbl%0d_writes", i), 32'(writes_seen - w0), 32'(tbl[i].wr));
         check($sformatf("tbl%0d_errs", i), 32'(errs_seen - e0), 32'(tbl[i].er));
         check($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'd0);
         check($sformatf("tbl%0d_sel", i), 32'(bus.sel_out), 32'(tbl[i].sel));
         check($sformatf("tbl%0d_d0", i), 32'(bus.data_out[0]), 32'(tbl[i].d0));
         check($sformatf("tbl%0d_d1", i), 32'(bus.data_out[1]), 32'(tbl[i].d1));
      end

      // Back-to-back frames.
      w0 = writes_seen;
      expect_write(4'h5, 8'h11, 8'h22);
      expect_write(4'h6, 8'h33, 8'h44);
      send_frame(8'h15, 8'h11, 8'h22, 0);
      send_frame(8'h16, 8'h33, 8'h44, 0);
      idle(3);
      check("b2b_writes", 32'(writes_seen - w0), 32'd2);

      // Reset mid-frame discards the partial frame.
      send_byte(8'h13);
      send_byte(8'hAA);
      @(negedge clk);
      rst = 1'b1;
      idle(2);
      check("mrst_sel", 32'(bus.sel_out), 32'd0);
      check("mrst_d0", 32'(bus.data_out[0]), 32'd0);
      check("mrst_d1", 32'(bus.data_out[1]), 32'd0);
      check("mrst_busy", 32'(bus.busy), 32'd0);
      check("mrst_rx_ready", 32'(bus.rx_ready), 32'd0);
      check("mrst_write", 32'(bus.write), 32'd0);
      rst = 1'b0;
      w0 = writes_seen;
      expect_write(4'h3, 8'h01, 8'h02);
      send_frame(8'h13, 8'h01, 8'h02, 0);
      idle(3);
      check("t4_writes", 32'(writes_seen - w0), 32'd1);

      // BITS=12: little-endian, top nibble of each high byte dropped.
      ck12 = 8'h10 ^ 8'h34 ^ 8'hF2 ^ 8'hCD ^ 8'h0B;
      send_byte12(8'h10);
      send_byte12(8'h34);
      send_byte12(8'hF2);
      send_byte12(8'hCD);
      send_byte12(8'h0B);
`ifdef LOAD_CHECKSUM_EN
      send_byte12(ck12);
`endif
      check("b12_write", 32'(bus12.write), 32'd1);
      check("b12_sel", 32'(bus12.sel_out), 32'd0);
      check("b12_d0", 32'(bus12.data_out[0]), 32'h234);
      check("b12_d1", 32'(bus12.data_out[1]), 32'hBCD);
      idle(2);
      check("b12_busy", 32'(bus12.busy), 32'd0);

`ifdef LOAD_CHECKSUM_EN
      w0 = writes_seen;
      expect_write(4'h0, 8'h0F, 8'h3C);
      send_byte(8'h10);
      send_byte(8'h0F);
      send_byte(8'h3C);
      send_byte(8'h23);
      idle(3);
      check("ck_good_writes", 32'(writes_seen - w0), 32'd1);
      expect_write(4'h7, 8'h01, 8'h01);
      send_frame(8'h17, 8'h01, 8'h01, 0);
      idle(3);
      w0 = writes_seen;
      e0 = errs_seen;
      send_byte(8'h10);
      send_byte(8'h0F);
      send_byte(8'h3C);
      send_byte(8'h00);
      check("ck_bad_err", 32'(bus.err), 32'd1);
      idle(3);
      check("ck_bad_writes", 32'(writes_seen - w0), 32'd0);
      check("ck_bad_errs", 32'(errs_seen - e0), 32'd1);
      check("ck_bad_sel", 32'(bus.sel_out), 32'd0);
      check("ck_bad_busy", 32'(bus.busy), 32'd0);
`endif

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
